// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared constants for the 8N1 UART receiver: FSM state
//                encoding and frame shape.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Receiver FSM states (2-bit encoding)
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    // Frame shape: 8 data bits, no parity, 1 stop bit
    localparam int c_data_bits = 8;
    localparam int c_stop_bits = 1;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_baud_cnt
//  Description : Wrapping up-counter used as the receiver's sample-tick
//                generator. Counts 0..CNT_MAX while enabled and pulses o_en
//                on the terminal count. i_load preloads CNT_LOAD so the first
//                tick lands (CNT_MAX - CNT_LOAD + 1) cycles later; i_restart
//                clears to zero for a full-period wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_baud_cnt #(
    parameter int CNT_WIDTH = 16,
    parameter int CNT_MAX   = 15,
    parameter int CNT_LOAD  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_load,
    input  logic i_restart,
    output logic o_en
);

    localparam logic [CNT_WIDTH-1:0] c_max  = CNT_WIDTH'(CNT_MAX);
    localparam logic [CNT_WIDTH-1:0] c_load = CNT_WIDTH'(CNT_LOAD);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Load has priority, then restart, then normal wrapping count when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_max) ? '0 : r_cnt + 1'b1;
        end
    end

    // Tick only while enabled so a stale count in IDLE cannot fire
    assign o_en = i_en && (r_cnt == c_max);

endmodule : uart_rx_baud_cnt
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Synchronises the serial line, detects a
//                start-bit falling edge, samples each bit at its midpoint
//                using a clock-cycle baud divider and reports each byte with
//                a one-cycle valid strobe or a one-cycle framing-error strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD_DIV  = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_rx,
    output logic [c_data_bits-1:0] o_data,
    output logic                   o_vld,
    output logic                   o_frame_err,
    output logic                   o_busy
);

    localparam int c_half = BAUD_DIV / 2;
    localparam int c_bcw  = $clog2(c_data_bits);

    localparam logic [c_bcw-1:0] c_last_bit  = c_bcw'(c_data_bits - 1);
    localparam logic [c_bcw-1:0] c_last_stop = c_bcw'(c_stop_bits - 1);

    // Synchronizer chain plus history flop for edge detection
    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    // FSM and datapath state
    logic [1:0]             r_state;
    logic [c_bcw-1:0]       r_bit_cnt;
    logic [c_data_bits-1:0] r_shift;
    logic [c_data_bits-1:0] r_data;
    logic                   r_vld;
    logic                   r_err;
    logic                   r_busy;

    // Combinational controls
    logic [1:0] w_state_nxt;
    logic       w_fall;
    logic       w_tick;
    logic       w_restart;
    logic       w_shift_en;
    logic       w_good;
    logic       w_bad;

    // Start edge: synchronized line low while the previous sample was high
    assign w_fall = (r_state == c_st_idle) && !r_sync2 && r_hist;

    // Baud tick generator; the preload puts the first tick half a bit after D
    uart_rx_baud_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .CNT_MAX   (BAUD_DIV - 1),
        .CNT_LOAD  (BAUD_DIV - c_half)
    ) u_baud_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state != c_st_idle),
        .i_load    (w_fall),
        .i_restart (w_restart),
        .o_en      (w_tick)
    );

    // Two-flop synchronizer and history flop; reset high so no false start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Next-state logic; every sample decision is taken on a baud tick
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_shift_en  = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_fall) begin
                    w_state_nxt = c_st_start;
                end
            end
            c_st_start: begin
                if (w_tick) begin
                    if (!r_sync2) begin
                        w_state_nxt = c_st_data;
                        w_restart   = 1'b1;
                    end else begin
                        // Line back high at mid start bit: glitch, drop quietly
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            c_st_data: begin
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_nxt = c_st_stop;
                    end
                end
            end
            c_st_stop: begin
                if (w_tick) begin
                    if (!r_sync2) begin
                        w_bad       = 1'b1;
                        w_state_nxt = c_st_idle;
                    end else if (r_bit_cnt == c_last_stop) begin
                        w_good      = 1'b1;
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State, bit counter and busy flag; busy is registered alongside state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_st_idle);
            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_tick && (r_state == c_st_data || r_state == c_st_stop)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // LSB-first shift register and output strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_data  <= '0;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {r_sync2, r_shift[c_data_bits-1:1]};
            end
            if (w_good) begin
                r_data <= r_shift;
            end
            r_vld <= w_good;
            r_err <= w_bad;
        end
    end

    assign o_data      = r_data;
    assign o_vld       = r_vld;
    assign o_frame_err = r_err;
    assign o_busy      = r_busy;

endmodule : uart_rx
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-direction companion to the team's ROM-driven UART transmitter.
- Takes the asynchronous serial line, detects the start bit and samples each bit at its midpoint using a clock-cycle baud divider.
- Presents each received byte as a one-cycle valid strobe; reports framing errors separately.
- Sits between the board RX pin and any byte consumer, e.g. a loopback checker or command decoder.

Parameters:
- BAUD_DIV, 16, clock cycles per bit period; must be >= 4.
- CNT_WIDTH, 16, width of the internal baud counter; must satisfy 2^CNT_WIDTH > BAUD_DIV.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_rx  input  1  serial line, asynchronous to clk; idles high.
- o_data  output  8  last received byte; held stable until the next successful byte.
- o_vld  output  1  one-cycle pulse: o_data was updated with a good byte.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset values: o_data=8'h00, o_vld=0, o_frame_err=0, o_busy=0, state=IDLE.
- Synchronizer resets to 1, so no false start is seen after reset.
- Input path:
  - 2-flop synchronizer on i_rx, then one history flop.
  - Start detection uses the synchronized signal only.
  - Pin-to-detection latency is 2 cycles.
- HALF = BAUD_DIV/2, using integer division.
- Detection cycle D: the first cycle where the synchronized line is 0 and the history flop is 1, while in IDLE.
  - A line held low, such as a break, does not re-trigger.
  - A falling edge is required.
- IDLE -> START at D; the baud counter is loaded so its terminal tick fires at D+HALF.
- START, sample at D+HALF:
  - line 0 -> DATA; counter restarts for a full period.
  - line 1 -> IDLE; the event is treated as a glitch, with no output and no error.
- DATA:
  - Bit k (k=0..7, LSB first) is sampled at D+HALF+(k+1)*BAUD_DIV into a shift register.
  - After bit 7 -> STOP.
- STOP, sample at D+HALF+9*BAUD_DIV:
  - line 1 -> o_data updated with the shift register and o_vld=1 in the following cycle; -> IDLE.
  - line 0 -> o_frame_err=1 in the following cycle; o_data is unchanged; -> IDLE.
- Because of the history-flop rule, after a framing error a new frame is accepted only once the line has returned high and fallen again.
- Back-to-back frames:
  - IDLE is re-entered about half a bit before the nominal stop-bit end.
  - A start edge arriving immediately after the stop bit is detected normally.
- o_vld and o_frame_err are never high in the same cycle; each is exactly 1 cycle wide.
- o_busy = (state != IDLE), registered with the state.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronously). The partial byte is discarded and no strobe is produced.
- Baud counter:
  - Counts up to BAUD_DIV-1 and wraps to 0, producing one tick per period.
  - A load input overrides counting, for resynchronisation at D and after the start sample.
  - It is gated idle in IDLE.
- Required tolerance: correct reception with the transmitter bit period within ±3% of BAUD_DIV.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, START, DATA, STOP; 2 bits);
  - the frame constants DATA_BITS=8 and STOP_BITS=1.
- One sub-module: the team's existing counter block, used as the baud tick generator.
  - CNT_MAX = BAUD_DIV-1.
  - CNT_LOAD is chosen so the first tick after load lands HALF cycles later.
  - o_en is the sample tick.
- Synchronizer, FSM and shift register stay in uart_rx.

Test Plan:
- BAUD_DIV=16, send 0xA5 with ideal timing -> o_vld pulses once 1 cycle after the stop sample, o_data=0xA5, o_frame_err stays 0, o_busy high for ~9.5 bit periods.
- Back-to-back 0x00 then 0xFF with no idle gap -> two o_vld pulses exactly 10*16 cycles apart, with o_data 0x00 then 0xFF.
- 4-cycle low glitch on i_rx while idle -> no o_vld or o_frame_err; o_busy returns to 0 by D+HALF+1; a following 0x3C is received correctly.
- 0x3C sent with stop bit 0, then line held low for 30 bit times -> exactly one o_frame_err pulse, o_data keeps its previous value, no further activity until the line rises; a subsequent 0x5A is received correctly.
- rst_n pulsed low during data bit 4 of 0x81 -> all outputs 0 immediately, no strobe for the partial byte; a full 0x81 sent after release yields o_vld with o_data=0x81.
- Bit period 15 and 17 cycles (±6% at BAUD_DIV=16, beyond spec) for characterisation; then 16.48 cycles via fractional-period stimulus (+3%) sending 0xC3 -> o_data=0xC3, no framing error.
